riscv_wb_arbiter: RTL and testbench
===================================

Name: riscv_wb_arbiter

Overview:
- Shares the single integer register-file write port between three producers: the exec stage (single-cycle ALU/jump results), the load/store unit (LSU) and the multiply/divide unit (MULDIV).
- Exec always wins the port. LSU and MULDIV results are held in one-entry buffers and drained round-robin into idle slots.
- A starvation counter stalls issue when a buffered result has waited too long.
- The block also reports read-after-write hazards to the issue stage for results not yet written to the register file.

Parameters:
- STARVE_LIMIT, 4, wait cycles (1..15) a buffered result may go ungranted before stall_o asserts.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- exec_idx_i  in  5  exec writeback rd; 0 = no write
- exec_value_i  in  32  exec writeback value
- lsu_valid_i  in  1  LSU result valid
- lsu_idx_i  in  5  LSU rd
- lsu_value_i  in  32  LSU load data
- lsu_ready_o  out  1  LSU buffer empty
- muldiv_valid_i  in  1  MULDIV result valid
- muldiv_idx_i  in  5  MULDIV rd
- muldiv_value_i  in  32  MULDIV result
- muldiv_ready_o  out  1  MULDIV buffer empty
- rf_wr_en_o  out  1  register-file write enable
- rf_wr_idx_o  out  5  register-file write index
- rf_wr_value_o  out  32  register-file write data
- ra_idx_i  in  5  issue-stage source A index
- rb_idx_i  in  5  issue-stage source B index
- hazard_o  out  1  source operand pending and not bypassable
- byp_ra_valid_o  out  1  bypass value valid for A
- byp_ra_value_o  out  32  bypass value for A
- byp_rb_valid_o  out  1  bypass value valid for B
- byp_rb_value_o  out  32  bypass value for B
- stall_o  out  1  stall issue

Behaviour:
Clock and reset:
- One clock (clk_i); reset (rst_i) is asynchronous and active-high.
- On reset: rf_wr_en_o=0, rf_wr_idx_o=0, rf_wr_value_o=0, both buffers empty (ready outputs=1), wait counters=0, last-grant=MULDIV (so LSU wins the first tie), stall_o=0.
- Reset asserted mid-operation discards any buffered results.

Handshake and buffers:
- A source transfers when valid & ready. Ready = buffer empty (registered).
- A buffer drained in cycle N accepts again in N+1; there is no same-cycle refill.
- A transfer with idx=0 is accepted and discarded; the buffer stays empty.

Arbitration (per cycle):
- exec_idx_i!=0: exec is granted.
- Otherwise, if exactly one buffer is full, it is granted.
- If both buffers are full, the one not granted last is granted, and last-grant updates.
- The grant loads the output register; the full buffer clears at the same edge.

Latency:
- Exec: input cycle N -> rf_wr_* valid in N+1.
- Buffered source: accepted at edge N -> earliest rf_wr_* in N+2.
- rf_wr_en_o is 1 only when a grant occurred; otherwise 0 and the idx/value registers hold.

WAW ordering:
- An exec write whose idx matches a full buffer's idx clears that buffer in the same cycle; the stale result is never written.
- A new acceptance matching the other full buffer's idx clears the older one.
- LSU and MULDIV accepted in the same cycle with equal idx: the MULDIV entry is kept and the LSU entry is dropped.

Starvation:
- Each full buffer has a 4-bit wait counter. It increments per cycle full-and-not-granted, saturates at 15, and clears on grant or cancel.
- stall_o = any counter >= STARVE_LIMIT (combinational from registers).
- Issue holding lets exec_idx_i go to 0, so the buffer drains.

Hazard and bypass:
- For each source index (0 never matches), the newest pending producer is chosen in this priority: exec input this cycle > LSU/MULDIV buffer > output register.
- Without bypass (see Optional Feature), any match sets hazard_o.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: on a match, byp_r*_valid_o=1 and byp_r*_value_o=matching value; hazard_o=0.
- Undefined: byp_r*_valid_o and byp_r*_value_o tied to 0; hazard_o=1 on any match.

Decomposition:
- Shared package riscv_defs_pkg.sv: source-select enum (SRC_NONE, SRC_EXEC, SRC_LSU, SRC_MULDIV) and the register-index width constant.
- One natural sub-module, riscv_wb_buffer: one-entry buffer with cancel and wait counter, instanced twice.
- The arbiter and the hazard compare stay in the top level.

Test Plan:
- Exec only: exec_idx=5, value=0x1234 -> next cycle rf_wr_en=1, idx=5, value=0x1234; exec_idx=0 -> rf_wr_en=0.
- LSU vs exec: LSU idx=7 value=0xAA while exec writes every cycle; with STARVE_LIMIT=4, stall_o=1 after 4 waits; exec_idx drops to 0 -> x7=0xAA written, stall_o=0, lsu_ready=1.
- Tie: both buffers full, idx 3 and 4 -> LSU (x3) written first, MULDIV (x4) next cycle; repeat -> MULDIV wins.
- WAW: LSU idx=9 buffered, then exec idx=9 value=0x55 -> only 0x55 written to x9; LSU buffer empties without a write.
- Hazard: LSU idx=6 value=0x77 buffered, ra_idx=6 -> with bypass: byp_ra_valid=1, value=0x77, hazard=0; without: hazard=1. ra_idx=0 -> no hazard.
- Reset with both buffers full -> buffers empty, rf_wr_en=0, no writes after release.

Source files
------------

// File: rtl/riscv_defs_pkg.sv
// Shared writeback types: register index width, source-select enum,
// buffered result entry and the pending-producer match helper.
package riscv_defs_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EXEC,
    SRC_LSU,
    SRC_MULDIV
  } src_e;

  typedef struct packed {
    reg_idx_t idx;
    xword_t   value;
  } wb_entry_t;

  // One-hot pending-producer match, newest first.
  localparam int PM_EXEC   = 0;
  localparam int PM_LSU    = 1;
  localparam int PM_MULDIV = 2;
  localparam int PM_OUT    = 3;

  function automatic logic [3:0] pend_match(
    input reg_idx_t src,
    input reg_idx_t exec_idx,
    input logic     lsu_full,
    input reg_idx_t lsu_idx,
    input logic     md_full,
    input reg_idx_t md_idx,
    input logic     out_en,
    input reg_idx_t out_idx
  );
    logic [3:0] m;
    m = '0;
    if (src != '0) begin
      if (exec_idx == src)
        m[PM_EXEC] = 1'b1;
      else if (lsu_full && lsu_idx == src)
        m[PM_LSU] = 1'b1;
      else if (md_full && md_idx == src)
        m[PM_MULDIV] = 1'b1;
      else if (out_en && out_idx == src)
        m[PM_OUT] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/riscv_wb_buffer.sv
// One-entry writeback buffer with cancel and saturating wait counter.
// Ports: push_i/entry_i load, grant_i/cancel_i clear, full_o, entry_o, wait_o.
module riscv_wb_buffer
  import riscv_defs_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      grant_i,
  input  logic      cancel_i,
  output logic      full_o,
  output wb_entry_t entry_o,
  output logic [3:0] wait_o
);

  // push only happens while empty, grant/cancel only while full,
  // so the branches below never compete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_o  <= 1'b0;
      entry_o <= '0;
      wait_o  <= '0;
    end else if (push_i) begin
      full_o  <= 1'b1;
      entry_o <= entry_i;
      wait_o  <= '0;
    end else if (grant_i || cancel_i) begin
      full_o  <= 1'b0;
      wait_o  <= '0;
    end else if (full_o && wait_o != 4'd15) begin
      wait_o  <= wait_o + 4'd1;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: exec > buffered LSU/MULDIV (round-robin),
// starvation stall, RAW hazard/bypass. Optional macro: WB_ARB_BYPASS_EN.
module riscv_wb_arbiter
  import riscv_defs_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  exec_idx_i,
  input  logic [31:0] exec_value_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_idx_i,
  input  logic [31:0] lsu_value_i,
  output logic        lsu_ready_o,
  input  logic        muldiv_valid_i,
  input  logic [4:0]  muldiv_idx_i,
  input  logic [31:0] muldiv_value_i,
  output logic        muldiv_ready_o,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_value_o,
  input  logic [4:0]  ra_idx_i,
  input  logic [4:0]  rb_idx_i,
  output logic        hazard_o,
  output logic        byp_ra_valid_o,
  output logic [31:0] byp_ra_value_o,
  output logic        byp_rb_valid_o,
  output logic [31:0] byp_rb_value_o,
  output logic        stall_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       lsu_full, md_full;
  wb_entry_t  lsu_q, md_q;
  logic [3:0] lsu_wait, md_wait;
  logic       exec_wr;
  logic       lsu_acc, md_acc;
  logic       lsu_push, md_push;
  logic       lsu_cancel, md_cancel;
  logic       lsu_grant, md_grant;
  src_e       grant_sel;
  src_e       last_q;

  assign exec_wr = exec_idx_i != '0;

  assign lsu_ready_o    = ~lsu_full;
  assign muldiv_ready_o = ~md_full;

  // idx 0 transfers complete the handshake but are never stored.
  assign lsu_acc = lsu_valid_i & ~lsu_full & (lsu_idx_i != '0);
  assign md_acc  = muldiv_valid_i & ~md_full & (muldiv_idx_i != '0);

  // Same-cycle arrivals to one rd: MULDIV entry wins.
  assign lsu_push = lsu_acc & ~(md_acc & (muldiv_idx_i == lsu_idx_i));
  assign md_push  = md_acc;

  // Older buffered results overwritten by a newer producer are dropped.
  assign lsu_cancel = lsu_full &
    ((exec_wr & (exec_idx_i == lsu_q.idx)) |
     (md_push & (muldiv_idx_i == lsu_q.idx)));
  assign md_cancel = md_full &
    ((exec_wr & (exec_idx_i == md_q.idx)) |
     (lsu_push & (lsu_idx_i == md_q.idx)));

  always_comb begin
    grant_sel = SRC_NONE;
    if (exec_wr)
      grant_sel = SRC_EXEC;
    else if (lsu_full && md_full)
      grant_sel = (last_q == SRC_LSU) ? SRC_MULDIV : SRC_LSU;
    else if (lsu_full)
      grant_sel = SRC_LSU;
    else if (md_full)
      grant_sel = SRC_MULDIV;
  end

  assign lsu_grant = grant_sel == SRC_LSU;
  assign md_grant  = grant_sel == SRC_MULDIV;

  riscv_wb_buffer u_lsu_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (lsu_push),
    .entry_i  ('{idx: lsu_idx_i, value: lsu_value_i}),
    .grant_i  (lsu_grant),
    .cancel_i (lsu_cancel),
    .full_o   (lsu_full),
    .entry_o  (lsu_q),
    .wait_o   (lsu_wait)
  );

  riscv_wb_buffer u_md_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (md_push),
    .entry_i  ('{idx: muldiv_idx_i, value: muldiv_value_i}),
    .grant_i  (md_grant),
    .cancel_i (md_cancel),
    .full_o   (md_full),
    .entry_o  (md_q),
    .wait_o   (md_wait)
  );

  // Round-robin pointer only moves on a real tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      last_q <= SRC_MULDIV;
    else if (lsu_full && md_full && !exec_wr)
      last_q <= grant_sel;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wr_en_o    <= 1'b0;
      rf_wr_idx_o   <= '0;
      rf_wr_value_o <= '0;
    end else begin
      rf_wr_en_o <= grant_sel != SRC_NONE;
      unique case (grant_sel)
        SRC_EXEC: begin
          rf_wr_idx_o   <= exec_idx_i;
          rf_wr_value_o <= exec_value_i;
        end
        SRC_LSU: begin
          rf_wr_idx_o   <= lsu_q.idx;
          rf_wr_value_o <= lsu_q.value;
        end
        SRC_MULDIV: begin
          rf_wr_idx_o   <= md_q.idx;
          rf_wr_value_o <= md_q.value;
        end
        default: ;
      endcase
    end
  end

  assign stall_o = (lsu_wait >= LIMIT) | (md_wait >= LIMIT);

  logic [3:0] ra_m, rb_m;

  assign ra_m = pend_match(ra_idx_i, exec_idx_i,
    lsu_full, lsu_q.idx, md_full, md_q.idx,
    rf_wr_en_o, rf_wr_idx_o);
  assign rb_m = pend_match(rb_idx_i, exec_idx_i,
    lsu_full, lsu_q.idx, md_full, md_q.idx,
    rf_wr_en_o, rf_wr_idx_o);

`ifdef WB_ARB_BYPASS_EN
  function automatic xword_t pick(
    input logic [3:0] m,
    input xword_t     ex_v,
    input xword_t     lsu_v,
    input xword_t     md_v,
    input xword_t     out_v
  );
    xword_t v;
    v = '0;
    unique case (1'b1)
      m[PM_EXEC]:   v = ex_v;
      m[PM_LSU]:    v = lsu_v;
      m[PM_MULDIV]: v = md_v;
      m[PM_OUT]:    v = out_v;
      default:      v = '0;
    endcase
    return v;
  endfunction

  assign hazard_o       = 1'b0;
  assign byp_ra_valid_o = |ra_m;
  assign byp_rb_valid_o = |rb_m;
  assign byp_ra_value_o = pick(ra_m, exec_value_i,
    lsu_q.value, md_q.value, rf_wr_value_o);
  assign byp_rb_value_o = pick(rb_m, exec_value_i,
    lsu_q.value, md_q.value, rf_wr_value_o);
`else
  assign hazard_o       = (|ra_m) | (|rb_m);
  assign byp_ra_valid_o = 1'b0;
  assign byp_rb_valid_o = 1'b0;
  assign byp_ra_value_o = '0;
  assign byp_rb_value_o = '0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter.
// Covers exec path, starvation, tie, WAW, hazard/bypass, reset.
module tb_riscv_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  exec_idx_i = '0;
  logic [31:0] exec_value_i = '0;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_idx_i = '0;
  logic [31:0] lsu_value_i = '0;
  logic        lsu_ready_o;
  logic        muldiv_valid_i = 1'b0;
  logic [4:0]  muldiv_idx_i = '0;
  logic [31:0] muldiv_value_i = '0;
  logic        muldiv_ready_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic [4:0]  ra_idx_i = '0;
  logic [4:0]  rb_idx_i = '0;
  logic        hazard_o;
  logic        byp_ra_valid_o;
  logic [31:0] byp_ra_value_o;
  logic        byp_rb_valid_o;
  logic [31:0] byp_rb_value_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  riscv_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .exec_idx_i     (exec_idx_i),
    .exec_value_i   (exec_value_i),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_idx_i      (lsu_idx_i),
    .lsu_value_i    (lsu_value_i),
    .lsu_ready_o    (lsu_ready_o),
    .muldiv_valid_i (muldiv_valid_i),
    .muldiv_idx_i   (muldiv_idx_i),
    .muldiv_value_i (muldiv_value_i),
    .muldiv_ready_o (muldiv_ready_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_idx_o    (rf_wr_idx_o),
    .rf_wr_value_o  (rf_wr_value_o),
    .ra_idx_i       (ra_idx_i),
    .rb_idx_i       (rb_idx_i),
    .hazard_o       (hazard_o),
    .byp_ra_valid_o (byp_ra_valid_o),
    .byp_ra_value_o (byp_ra_value_o),
    .byp_rb_valid_o (byp_rb_valid_o),
    .byp_rb_value_o (byp_rb_value_o),
    .stall_o        (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    checks++;
    if (rf_wr_en_o !== 1'b0 || rf_wr_idx_o !== 5'd0 ||
        rf_wr_value_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got en=%b idx=%0d val=%h exp 0/0/0",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o);
    end
    checks++;
    if (lsu_ready_o !== 1'b1 || muldiv_ready_o !== 1'b1 ||
        stall_o !== 1'b0 || hazard_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b%b stall=%b haz=%b exp 11/0/0",
               lsu_ready_o, muldiv_ready_o, stall_o, hazard_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_exec();
    exec_idx_i = 5'd5;
    exec_value_i = 32'h1234;
    step();
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== 5'd5 ||
        rf_wr_value_o !== 32'h1234) begin
      errors++;
      $display("FAIL exec_write got en=%b idx=%0d val=%h exp 1/5/1234",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o);
    end
    exec_idx_i = 5'd0;
    step();
    checks++;
    if (rf_wr_en_o !== 1'b0 || rf_wr_idx_o !== 5'd5 ||
        rf_wr_value_o !== 32'h1234) begin
      errors++;
      $display("FAIL exec_idle got en=%b idx=%0d val=%h exp 0/5/1234",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o);
    end
  endtask

  task automatic test_starve();
    exec_idx_i = 5'd1;
    exec_value_i = 32'h10;
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd7;
    lsu_value_i = 32'hAA;
    step();
    lsu_valid_i = 1'b0;
    checks++;
    if (lsu_ready_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_accept got rdy=%b stall=%b exp 0/0",
               lsu_ready_o, stall_o);
    end
    for (int i = 0; i < 3; i++) begin
      exec_value_i = 32'h11 + 32'(i);
      step();
    end
    checks++;
    if (stall_o !== 1'b0 || rf_wr_idx_o !== 5'd1) begin
      errors++;
      $display("FAIL starve_3waits got stall=%b idx=%0d exp 0/1",
               stall_o, rf_wr_idx_o);
    end
    step();
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_4waits got stall=%b exp 1", stall_o);
    end
    exec_idx_i = 5'd0;
    step();
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== 5'd7 ||
        rf_wr_value_o !== 32'hAA || stall_o !== 1'b0 ||
        lsu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_drain got en=%b idx=%0d val=%h stall=%b rdy=%b exp 1/7/aa/0/1",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, stall_o, lsu_ready_o);
    end
    step();
  endtask

  task automatic test_tie();
    logic [4:0] first_idx [2];
    logic [4:0] second_idx [2];
    first_idx[0] = 5'd3;
    second_idx[0] = 5'd4;
    first_idx[1] = 5'd4;
    second_idx[1] = 5'd3;
    for (int r = 0; r < 2; r++) begin
      lsu_valid_i = 1'b1;
      lsu_idx_i = 5'd3;
      lsu_value_i = 32'h33 + 32'(r * 'h300);
      muldiv_valid_i = 1'b1;
      muldiv_idx_i = 5'd4;
      muldiv_value_i = 32'h44 + 32'(r * 'h400);
      step();
      lsu_valid_i = 1'b0;
      muldiv_valid_i = 1'b0;
      checks++;
      if (rf_wr_en_o !== 1'b0 || lsu_ready_o !== 1'b0 ||
          muldiv_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL tie_fill%0d got en=%b rdy=%b%b exp 0/00",
                 r, rf_wr_en_o, lsu_ready_o, muldiv_ready_o);
      end
      step();
      checks++;
      if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== first_idx[r]) begin
        errors++;
        $display("FAIL tie_first%0d got en=%b idx=%0d exp 1/%0d",
                 r, rf_wr_en_o, rf_wr_idx_o, first_idx[r]);
      end
      step();
      checks++;
      if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== second_idx[r] ||
          lsu_ready_o !== 1'b1 || muldiv_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL tie_second%0d got en=%b idx=%0d rdy=%b%b exp 1/%0d/11",
                 r, rf_wr_en_o, rf_wr_idx_o, lsu_ready_o, muldiv_ready_o,
                 second_idx[r]);
      end
      step();
    end
  endtask

  task automatic test_waw();
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd9;
    lsu_value_i = 32'h99;
    step();
    lsu_valid_i = 1'b0;
    exec_idx_i = 5'd9;
    exec_value_i = 32'h55;
    step();
    exec_idx_i = 5'd0;
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== 5'd9 ||
        rf_wr_value_o !== 32'h55 || lsu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL waw_exec got en=%b idx=%0d val=%h rdy=%b exp 1/9/55/1",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, lsu_ready_o);
    end
    step();
    checks++;
    if (rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_no_stale got en=%b exp 0", rf_wr_en_o);
    end
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd10;
    lsu_value_i = 32'h1;
    muldiv_valid_i = 1'b1;
    muldiv_idx_i = 5'd10;
    muldiv_value_i = 32'h2;
    step();
    lsu_valid_i = 1'b0;
    muldiv_valid_i = 1'b0;
    checks++;
    if (lsu_ready_o !== 1'b1 || muldiv_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_same_cycle got rdy=%b%b exp 10",
               lsu_ready_o, muldiv_ready_o);
    end
    step();
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_wr_idx_o !== 5'd10 ||
        rf_wr_value_o !== 32'h2) begin
      errors++;
      $display("FAIL waw_md_kept got en=%b idx=%0d val=%h exp 1/10/2",
               rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o);
    end
    step();
    checks++;
    if (rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL waw_lsu_dropped got en=%b exp 0", rf_wr_en_o);
    end
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd0;
    lsu_value_i = 32'hDEAD;
    step();
    lsu_valid_i = 1'b0;
    checks++;
    if (lsu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idx0_discard got rdy=%b exp 1", lsu_ready_o);
    end
    step();
    checks++;
    if (rf_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL idx0_nowrite got en=%b exp 0", rf_wr_en_o);
    end
  endtask

  task automatic test_hazard();
    logic        exp_haz;
    logic        exp_v;
    logic [31:0] exp_val_buf;
    logic [31:0] exp_val_ex;
`ifdef WB_ARB_BYPASS_EN
    exp_haz = 1'b0;
    exp_v = 1'b1;
    exp_val_buf = 32'h77;
    exp_val_ex = 32'h88;
`else
    exp_haz = 1'b1;
    exp_v = 1'b0;
    exp_val_buf = 32'h0;
    exp_val_ex = 32'h0;
`endif
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd6;
    lsu_value_i = 32'h77;
    exec_idx_i = 5'd2;
    exec_value_i = 32'h20;
    step();
    lsu_valid_i = 1'b0;
    ra_idx_i = 5'd6;
    rb_idx_i = 5'd0;
    #1;
    checks++;
    if (hazard_o !== exp_haz || byp_ra_valid_o !== exp_v ||
        byp_ra_value_o !== exp_val_buf || byp_rb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_buf got haz=%b av=%b a=%h bv=%b exp %b/%b/%h/0",
               hazard_o, byp_ra_valid_o, byp_ra_value_o, byp_rb_valid_o,
               exp_haz, exp_v, exp_val_buf);
    end
    ra_idx_i = 5'd0;
    rb_idx_i = 5'd6;
    exec_idx_i = 5'd6;
    exec_value_i = 32'h88;
    #1;
    checks++;
    if (hazard_o !== exp_haz || byp_rb_valid_o !== exp_v ||
        byp_rb_value_o !== exp_val_ex || byp_ra_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_exec_prio got haz=%b bv=%b b=%h av=%b exp %b/%b/%h/0",
               hazard_o, byp_rb_valid_o, byp_rb_value_o, byp_ra_valid_o,
               exp_haz, exp_v, exp_val_ex);
    end
    exec_idx_i = 5'd2;
    rb_idx_i = 5'd0;
    #1;
    checks++;
    if (hazard_o !== 1'b0 || byp_ra_valid_o !== 1'b0 ||
        byp_rb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_idx0 got haz=%b v=%b%b exp 0/00",
               hazard_o, byp_ra_valid_o, byp_rb_valid_o);
    end
    exec_idx_i = 5'd0;
    step();
    ra_idx_i = 5'd6;
    #1;
    checks++;
    if (rf_wr_idx_o !== 5'd6 || hazard_o !== exp_haz ||
        byp_ra_valid_o !== exp_v || byp_ra_value_o !== exp_val_buf) begin
      errors++;
      $display("FAIL hazard_outreg got idx=%0d haz=%b av=%b a=%h exp 6/%b/%b/%h",
               rf_wr_idx_o, hazard_o, byp_ra_valid_o, byp_ra_value_o,
               exp_haz, exp_v, exp_val_buf);
    end
    step();
    checks++;
    if (hazard_o !== 1'b0 || byp_ra_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hazard_clear got haz=%b av=%b exp 0/0",
               hazard_o, byp_ra_valid_o);
    end
    ra_idx_i = 5'd0;
  endtask

  task automatic test_reset_mid();
    exec_idx_i = 5'd1;
    exec_value_i = 32'h1;
    lsu_valid_i = 1'b1;
    lsu_idx_i = 5'd11;
    lsu_value_i = 32'hB;
    muldiv_valid_i = 1'b1;
    muldiv_idx_i = 5'd12;
    muldiv_value_i = 32'hC;
    step();
    lsu_valid_i = 1'b0;
    muldiv_valid_i = 1'b0;
    checks++;
    if (lsu_ready_o !== 1'b0 || muldiv_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fill got rdy=%b%b exp 00",
               lsu_ready_o, muldiv_ready_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (lsu_ready_o !== 1'b1 || muldiv_ready_o !== 1'b1 ||
        rf_wr_en_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got rdy=%b%b en=%b stall=%b exp 11/0/0",
               lsu_ready_o, muldiv_ready_o, rf_wr_en_o, stall_o);
    end
    exec_idx_i = 5'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rf_wr_en_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nowrite%0d got en=%b exp 0", i, rf_wr_en_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exec();
    test_starve();
    test_tie();
    test_waw();
    test_hazard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
